receiver: RTL and testbench
===========================

# receiver

Serial receive stage of the SPART, the counterpart of the transmitter on the `rxd` side. It oversamples `rxd` using the 16x-baud receive enable from the baud downcounter and deframes 8N1 characters (LSB first). It holds each received byte in a data register for the bus interface and reports status: receive data available, framing error and overrun. A bus read at I/O address 00 consumes the byte.

## Interface
Parameters: none. Frame format is fixed at 8 data bits, no parity, 1 stop bit, with 16 enable ticks per bit.
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset; asynchronous, active-high
- `baud_r_enable`  in  1  single-`clk` tick at 16x the baud rate, from the baud downcounter
- `rxd`  in  1  serial input; asynchronous to `clk`; idles high
- `read_en`  in  1  bus read of the receive buffer (`iocs` & `ioaddr`==00 & `iorw`==1); one-cycle pulse
- `data`  out  8  last received byte
- `rda`  out  1  receive data available
- `ferr`  out  1  framing error on the byte held in `data`
- `ovr`  out  1  overrun: a byte was overwritten before it was read
- `busy`  out  1  a frame is in progress (state is not IDLE)

## Operation
- `rxd` passes through a 2-flop synchronizer, reset to 1. All sampling uses the synchronized value `rxd_s`.
- Counters: `tick_cnt` (4 bits) and `bit_cnt` (3 bits). Both advance only on `baud_r_enable`.
- Shift register `sh[7:0]` shifts right, with each sampled bit entering at bit 7. After 8 shifts, bit 0 of the first received bit sits in `sh[0]`.
- FSM; all transitions occur only on cycles with `baud_r_enable`=1:
  - IDLE: if `rxd_s`=0, go to START with `tick_cnt`=0.
  - START: if `tick_cnt`=7 (start-bit midpoint):
    - `rxd_s`=0: go to DATA, `tick_cnt`=0, `bit_cnt`=0.
    - `rxd_s`=1: false start, go to IDLE.
    - Otherwise increment `tick_cnt`.
  - DATA: if `tick_cnt`=15, shift `rxd_s` into `sh`, set `tick_cnt`=0, increment `bit_cnt`. If `bit_cnt` was 7, go to STOP. Otherwise increment `tick_cnt`.
  - STOP: if `tick_cnt`=15, sample the stop bit, go to IDLE (the complete event). Otherwise increment `tick_cnt`.
- On the complete event:
  - `data`<=`sh`, `rda`<=1.
  - `ferr`<=~`rxd_s`. The byte is delivered even when framing is bad.
  - `ovr`<=1 if `rda` was 1 and `read_en` is not asserted in this cycle. Otherwise `ovr` keeps its value.
- `read_en` alone: clears `rda`, `ferr` and `ovr` on the next edge. `data` is unchanged.
- `read_en` in the same cycle as the complete event: the complete event wins. `rda`=1, new `data`, `ferr` from the new stop bit, `ovr` unchanged.
- After a framing error, the receiver goes to IDLE. If the line is still low, the next tick in IDLE re-detects a start.
- `busy` = (state != IDLE), registered with the state.
- `rst` at any point, including mid-frame, returns to IDLE immediately. Partial frames are discarded.

## Timing
- Reset values: `data`=0x00, `rda`=0, `ferr`=0, `ovr`=0, `busy`=0. Synchronizer flops are 1. State is IDLE; all counters are 0.
- Tick T0 is the first tick with `rxd_s`=0 in IDLE. `rxd_s` lags `rxd` by 2 `clk` cycles.
- Sample points, relative to T0:
  - start-bit midpoint: T0+8 ticks
  - data bit i (i=0..7): T0+8+16(i+1) ticks
  - stop bit: T0+152 ticks
- `data`, `rda`, `ferr` and `ovr` update on the `clk` edge of the stop-sample tick. They are visible 1 `clk` after that tick's cycle.
- The receiver is back in IDLE and able to detect a new start 1 tick after the stop sample. This allows back-to-back frames with a single stop bit.
- `busy` rises 1 `clk` after T0 and falls with the complete event or a false start.

## Test plan
- Divisor giving 16 `clk`/tick; send 0xA5 with a good stop bit -> `data`=0xA5, `rda`=1, `ferr`=0 at T0+152 ticks + 1 `clk`; `read_en` pulse -> `rda`=0 on the next edge, `data` still 0xA5.
- Pull `rxd` low for 4 ticks, then high -> START is entered and aborted at T0+8, `busy` drops, `rda` stays 0, `data` is unchanged.
- Send 0x3C with stop bit 0 -> `data`=0x3C, `rda`=1, `ferr`=1; then send 0x55 with a good stop after a read -> `ferr`=0.
- Send 0x11 and 0x22 back-to-back with no read -> `data`=0x22, `rda`=1, `ovr`=1; `read_en` -> `rda`=`ovr`=0.
- Assert `read_en` in the exact cycle 0x22's stop is sampled, with 0x11 unread -> `rda`=1, `data`=0x22, `ovr`=0.
- Assert `rst` at bit 4 of a frame, release, then send 0x81 -> every output reads its reset value during reset, and the following frame gives `data`=0x81, `ferr`=0, `ovr`=0.

Source files
------------

// File: rtl/receiver.sv
// SPART receive stage: 2-flop rxd synchronizer, 16x oversampled 8N1 deframer,
// receive buffer with rda / framing-error / overrun status cleared by a bus read.
module receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_r_enable,
  input  logic       rxd,
  input  logic       read_en,
  output logic [7:0] data,
  output logic       rda,
  output logic       ferr,
  output logic       ovr,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_sh;
  logic [7:0]  r_data;
  logic        r_rda;
  logic        r_ferr;
  logic        r_ovr;
  logic        r_busy;
  logic        w_rxd_s;

  assign w_rxd_s = r_sync2;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_cnt  <= 3'd0;
      r_sh       <= 8'h00;
      r_data     <= 8'h00;
      r_rda      <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (read_en) begin
        r_rda  <= 1'b0;
        r_ferr <= 1'b0;
        r_ovr  <= 1'b0;
      end
      if (baud_r_enable) begin
        unique case (r_state)
          IDLE: begin
            if (!w_rxd_s) begin
              r_state    <= START;
              r_tick_cnt <= 4'd0;
              r_busy     <= 1'b1;
            end
          end
          START: begin
            if (r_tick_cnt == 4'd7) begin
              if (!w_rxd_s) begin
                r_state    <= DATA;
                r_tick_cnt <= 4'd0;
                r_bit_cnt  <= 3'd0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          DATA: begin
            if (r_tick_cnt == 4'd15) begin
              r_sh       <= {w_rxd_s, r_sh[7:1]};
              r_tick_cnt <= 4'd0;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          STOP: begin
            if (r_tick_cnt == 4'd15) begin
              // Completion overrides a coincident read; ovr keeps its value then.
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_tick_cnt <= 4'd0;
              r_data     <= r_sh;
              r_rda      <= 1'b1;
              r_ferr     <= ~w_rxd_s;
              r_ovr      <= (r_rda && !read_en) ? 1'b1 : r_ovr;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data = r_data;
  assign rda  = r_rda;
  assign ferr = r_ferr;
  assign ovr  = r_ovr;
  assign busy = r_busy;

endmodule

// File: tb/tb_receiver.sv
// Directed bench for receiver: 16 clk per tick, frames driven bit-by-bit,
// outputs checked on the falling clock edge against hand-computed values.
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_r_enable = 1'b0;
  logic       rxd = 1'b1;
  logic       read_en = 1'b0;
  logic [7:0] data;
  logic       rda;
  logic       ferr;
  logic       ovr;
  logic       busy;

  logic [3:0] div = 4'd0;
  int         n_checks = 0;
  int         n_fail = 0;

  receiver dut (
    .clk           (clk),
    .rst           (rst),
    .baud_r_enable (baud_r_enable),
    .rxd           (rxd),
    .read_en       (read_en),
    .data          (data),
    .rda           (rda),
    .ferr          (ferr),
    .ovr           (ovr),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One clk: advance to the falling edge and set the tick for the next rising edge.
  task automatic step();
    @(negedge clk);
    div = div + 4'd1;
    baud_r_enable = (div == 4'd0);
  endtask

  task automatic idle_ticks(input int n);
    rxd = 1'b1;
    repeat (n * 16) step();
  endtask

  task automatic rd_pulse();
    read_en = 1'b1;
    step();
    read_en = 1'b0;
  endtask

  // Frame falls just before a tick; T0 is the next tick and the stop sample
  // lands on the rising edge after step 2448. stop_at truncates the frame.
  task automatic send(input logic [7:0] b, input logic stop, input bit rd_at_stop,
                      input int stop_at);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    while (div != 4'd0) step();
    rxd = 1'b0;
    for (int k = 1; k < 2560; k++) begin
      if (k == stop_at) return;
      step();
      rxd     = frame[k / 256];
      read_en = rd_at_stop && (k == 2448);
    end
    read_en = 1'b0;
  endtask

  initial begin
    repeat (4) step();
    check("rst_data", data, 8'h00);
    check("rst_rda",  rda,  1'b0);
    check("rst_ferr", ferr, 1'b0);
    check("rst_ovr",  ovr,  1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle_ticks(4);

    send(8'hA5, 1'b1, 1'b0, 0);
    check("a5_data", data, 8'hA5);
    check("a5_rda",  rda,  1'b1);
    check("a5_ferr", ferr, 1'b0);
    check("a5_ovr",  ovr,  1'b0);
    check("a5_busy", busy, 1'b0);
    rd_pulse();
    check("a5_rd_rda",  rda,  1'b0);
    check("a5_rd_data", data, 8'hA5);
    idle_ticks(4);

    while (div != 4'd0) step();
    rxd = 1'b0;
    repeat (64) step();
    rxd = 1'b1;
    check("fs_busy_hi", busy, 1'b1);
    repeat (128) step();
    check("fs_busy_lo", busy, 1'b0);
    check("fs_rda",     rda,  1'b0);
    check("fs_data",    data, 8'hA5);
    idle_ticks(4);

    send(8'h3C, 1'b0, 1'b0, 0);
    check("3c_data", data, 8'h3C);
    check("3c_rda",  rda,  1'b1);
    check("3c_ferr", ferr, 1'b1);
    idle_ticks(20);
    check("3c_busy", busy, 1'b0);
    rd_pulse();
    check("3c_rd_ferr", ferr, 1'b0);
    send(8'h55, 1'b1, 1'b0, 0);
    check("55_data", data, 8'h55);
    check("55_rda",  rda,  1'b1);
    check("55_ferr", ferr, 1'b0);
    rd_pulse();
    idle_ticks(4);

    send(8'h11, 1'b1, 1'b0, 0);
    send(8'h22, 1'b1, 1'b0, 0);
    check("b2b_data", data, 8'h22);
    check("b2b_rda",  rda,  1'b1);
    check("b2b_ovr",  ovr,  1'b1);
    rd_pulse();
    check("b2b_rd_rda", rda, 1'b0);
    check("b2b_rd_ovr", ovr, 1'b0);
    idle_ticks(4);

    send(8'h11, 1'b1, 1'b0, 0);
    send(8'h22, 1'b1, 1'b1, 0);
    check("coin_data", data, 8'h22);
    check("coin_rda",  rda,  1'b1);
    check("coin_ovr",  ovr,  1'b0);
    check("coin_ferr", ferr, 1'b0);
    idle_ticks(4);

    send(8'hF0, 1'b1, 1'b0, 5 * 256 + 128);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mr_data", data, 8'h00);
    check("mr_rda",  rda,  1'b0);
    check("mr_ferr", ferr, 1'b0);
    check("mr_ovr",  ovr,  1'b0);
    check("mr_busy", busy, 1'b0);
    rxd = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    idle_ticks(4);
    send(8'h81, 1'b1, 1'b0, 0);
    check("81_data", data, 8'h81);
    check("81_rda",  rda,  1'b1);
    check("81_ferr", ferr, 1'b0);
    check("81_ovr",  ovr,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
